// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAIT,
    SETTLE,
    RUN,
    FAIL
  } pll_state_e;

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset / lock / settle / retry sequencer producing core reset and clock enable.
// Optional lock-loss counter output enabled by PLL_LOSS_CNT_EN.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
  parameter int unsigned STABLE_CYC       = 1024,
  parameter int unsigned RETRY_MAX        = 7,
  parameter int unsigned CE_DIV           = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               soft_req,
  output logic               pll_rst,
  output logic               sys_reset_n,
  output logic               ce,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retries
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  loss_cnt
`endif
);

  localparam int unsigned CNT_MAX = max3(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned CE_W    = $clog2(CE_DIV);

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic [CE_W-1:0]    div_q, div_d;
  logic               ce_d;
  logic               locked_s;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // State register plus registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PLLRST;
      cnt_q       <= '0;
      retries_q   <= '0;
      div_q       <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      ce          <= 1'b0;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      div_q       <= div_d;
      pll_rst     <= (state_d == PLLRST);
      sys_reset_n <= (state_d == RUN);
      ce          <= ce_d;
      ready       <= (state_d == RUN);
      fail        <= (state_d == FAIL);
    end
  end

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    unique case (state_q)
      PLLRST: begin
        if (cnt_q == CNT_W'(RST_PULSE_CYC - 1)) state_d = WAIT;
      end
      WAIT: begin
        if (locked_s) begin
          state_d = SETTLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
          if (retries_q < RETRY_W'(RETRY_MAX)) retries_d = retries_q + RETRY_W'(1);
          state_d = (retries_d == RETRY_W'(RETRY_MAX)) ? FAIL : PLLRST;
        end
      end
      SETTLE: begin
        if (!locked_s) state_d = WAIT;
        else if (cnt_q == CNT_W'(STABLE_CYC - 1)) state_d = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_d   = PLLRST;
          retries_d = '0;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: state_d = PLLRST;
    endcase

    // A restart request overrides any timeout or lock-loss decision.
    if (soft_req) begin
      state_d   = PLLRST;
      retries_d = '0;
    end

    cnt_d = (soft_req || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);

    div_d = '0;
    if (state_d == RUN && state_q == RUN)
      div_d = (div_q == CE_W'(CE_DIV - 1)) ? '0 : div_q + CE_W'(1);
    ce_d = (state_d == RUN) && (div_d == '0);
  end

  assign retries = retries_q;

`ifdef PLL_LOSS_CNT_EN
  logic loss_inc;
  assign loss_inc = (state_q == RUN) && !locked_s && !soft_req;

  // Counts lock-loss restarts from RUN; survives soft restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                 loss_cnt <= '0;
    else if (loss_inc && (loss_cnt != '1))        loss_cnt <= loss_cnt + LOSS_W'(1);
  end
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed scenarios plus random lock/soft_req traffic.
module tb_pll_reset_seq;

  localparam int T_RST = 4;
  localparam int T_TO  = 32;
  localparam int T_ST  = 8;
  localparam int R_MAX = 3;
  localparam int DIV   = 4;

  localparam int PH_RST    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SETTLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ce;
  logic       ready;
  logic       fail;
  logic [3:0] retries;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  pll_reset_seq #(
    .RST_PULSE_CYC    (T_RST),
    .LOCK_TIMEOUT_CYC (T_TO),
    .STABLE_CYC       (T_ST),
    .RETRY_MAX        (R_MAX),
    .CE_DIV           (DIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .soft_req    (soft_req),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .ce          (ce),
    .ready       (ready),
    .fail        (fail),
    .retries     (retries)
`ifdef PLL_LOSS_CNT_EN
    ,
    .loss_cnt    (loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: phase plus time spent in it, lock seen through a 2-deep delay line.
  int ph, el, rt, loss;
  bit s1, s2;

  task automatic go(input int p);
    if (p != ph) begin
      ph = p;
      el = 0;
    end else begin
      el++;
    end
  endtask

  task automatic model_reset();
    ph = PH_RST; el = 0; rt = 0; loss = 0; s1 = 0; s2 = 0;
  endtask

  task automatic model_step();
    bit ls;
    ls = s2;
    s2 = s1;
    s1 = pll_locked;
    if (soft_req) begin
      ph = PH_RST; el = 0; rt = 0;
    end else begin
      case (ph)
        PH_RST:    go((el + 1 >= T_RST) ? PH_WAIT : PH_RST);
        PH_WAIT: begin
          if (ls) go(PH_SETTLE);
          else if (el + 1 >= T_TO) begin
            rt = (rt + 1 > R_MAX) ? R_MAX : rt + 1;
            go((rt >= R_MAX) ? PH_FAIL : PH_RST);
          end else go(PH_WAIT);
        end
        PH_SETTLE: begin
          if (!ls) go(PH_WAIT);
          else go((el + 1 >= T_ST) ? PH_RUN : PH_SETTLE);
        end
        PH_RUN: begin
          if (!ls) begin
            rt = 0;
            loss = (loss < 255) ? loss + 1 : 255;
            go(PH_RST);
          end else go(PH_RUN);
        end
        default:   go(PH_FAIL);
      endcase
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("pll_rst",     32'(pll_rst),     32'(ph == PH_RST));
      check("sys_reset_n", 32'(sys_reset_n), 32'(ph == PH_RUN));
      check("ready",       32'(ready),       32'(ph == PH_RUN));
      check("fail",        32'(fail),        32'(ph == PH_FAIL));
      check("ce",          32'(ce),          32'((ph == PH_RUN) && (el % DIV == 0)));
      check("retries",     32'(retries),     32'(rt));
`ifdef PLL_LOSS_CNT_EN
      check("loss_cnt",    32'(loss_cnt),    32'(loss));
`endif
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ready), 32'd1);
  endtask

  task automatic wait_settle(input int budget);
    int n = 0;
    while (!(ph == PH_SETTLE && el == 5) && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    pll_locked = 1'b0;
    soft_req   = 1'b0;
    #1 reset_n = 1'b0;
    #1 mon_en  = 1;
    cycles(3);
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_sys_reset_n", 32'(sys_reset_n), 32'd0);
    check("rst_retries", 32'(retries), 32'd0);

    // Normal bring-up: lock arrives 10 cycles after release.
    reset_n = 1'b1;
    cycles(10);
    pll_locked = 1'b1;
    wait_ready("bringup_ready", 60);
    cycles(12);

    // Glitch during settling: back to waiting, no retry charged.
    pll_locked = 1'b0;
    cycles(3);
    pll_locked = 1'b1;
    wait_settle(80);
    pll_locked = 1'b0;
    cycles(1);
    pll_locked = 1'b1;
    wait_ready("relock_ready", 60);
    check("glitch_retries", 32'(retries), 32'd0);
    cycles(9);

    // Lock loss in RUN at the same cycle as a soft request.
    pll_locked = 1'b0;
    cycles(2);
    soft_req = 1'b1;
    cycles(1);
    soft_req = 1'b0;
    check("softloss_pll_rst", 32'(pll_rst), 32'd1);
    cycles(2);
    pll_locked = 1'b1;
    wait_ready("softloss_ready", 60);

    // No lock at all: three timed-out attempts then FAIL.
    pll_locked = 1'b0;
    begin
      int n = 0;
      while (fail !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("fail_reached", 32'(fail), 32'd1);
    check("fail_retries", 32'(retries), 32'(R_MAX));
    cycles(20);
    check("fail_held", 32'(fail), 32'd1);
    soft_req = 1'b1;
    cycles(1);
    soft_req = 1'b0;
    check("softreq_pll_rst", 32'(pll_rst), 32'd1);
    check("softreq_fail", 32'(fail), 32'd0);
    check("softreq_retries", 32'(retries), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    cycles(T_RST + 6);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_pll_rst", 32'(pll_rst), 32'd1);
    check("async_sys_reset_n", 32'(sys_reset_n), 32'd0);
    check("async_ready", 32'(ready), 32'd0);
    check("async_fail", 32'(fail), 32'd0);
    check("async_retries", 32'(retries), 32'd0);
    cycles(2);
    reset_n = 1'b1;

    // Random lock segments with occasional soft requests.
    for (int seg = 0; seg < 150; seg++) begin
      int dur;
      pll_locked = ($urandom_range(0, 99) < 60);
      dur = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 20);
      if (!pll_locked && $urandom_range(0, 15) == 0) dur = 160;
      repeat (dur) begin
        soft_req = ($urandom_range(0, 99) == 0);
        @(negedge clk);
      end
      soft_req = 1'b0;
    end

    cycles(4);
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
